// File: rtl/sound_mixer_pkg.sv
// Shared constants for the stereo sound mixer: sample geometry, IO register
// addresses and the mix sequencer state encoding.
package sound_mixer_pkg;

  localparam int DEF_SAMPLE_W  = 20;
  localparam int DEF_NUM_CH    = 4;
  localparam int DEF_OUT_SHIFT = 5;

  localparam logic [15:0] NR50_ADDR = 16'hFF24;
  localparam logic [15:0] NR51_ADDR = 16'hFF25;
  localparam logic [15:0] NR52_ADDR = 16'hFF26;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ACC,
    ST_SCALE,
    ST_FILT,
    ST_DONE
  } mix_state_t;

endpackage

// File: rtl/sound_mixer_dc_filter.sv
// Single-side DC-blocking stage: output is the input minus a slow running
// average (time constant ~256 samples). Used only with SOUND_MIXER_DC_FILTER_EN.
module sound_dc_filter
  import sound_mixer_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int AVG_W     = 28,
  parameter int AVG_SHIFT = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_step,
  input  logic                       i_bypass,
  input  logic signed [SAMPLE_W-1:0] i_x,
  output logic signed [SAMPLE_W-1:0] o_y
);

  logic signed [AVG_W-1:0]    r_avg;
  logic signed [SAMPLE_W-1:0] r_y;
  logic signed [AVG_W-1:0]    w_diff;

  assign w_diff = AVG_W'(i_x) - r_avg;

  // Bypassed (master-off) samples pass straight through and leave the average frozen.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_avg <= '0;
      r_y   <= '0;
    end else if (i_step) begin
      if (i_bypass) begin
        r_y <= i_x;
      end else begin
        r_y   <= SAMPLE_W'(w_diff);
        r_avg <= r_avg + (w_diff >>> AVG_SHIFT);
      end
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/sound_mixer.sv
// Stereo mixer: on each strobe snapshots the channel samples and NR50/NR51, pans,
// scales by master volume and emits one L/R pair. SOUND_MIXER_DC_FILTER_EN adds a DC blocker.
module sound_mixer
  import sound_mixer_pkg::*;
#(
  parameter int SAMPLE_W  = DEF_SAMPLE_W,
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int OUT_SHIFT = DEF_OUT_SHIFT
) (
  input  logic                       I_CLK,
  input  logic                       I_RESET_L,
  input  logic [15:0]                I_IOREG_ADDR,
  inout  wire  [7:0]                 IO_IOREG_DATA,
  input  logic                       I_IOREG_WE_L,
  input  logic                       I_IOREG_RE_L,
  input  logic [NUM_CH*SAMPLE_W-1:0] I_CH_WAVEFORM,
  input  logic [3:0]                 I_CH_ON,
  input  logic                       I_STROBE,
  output logic [SAMPLE_W-1:0]        O_LEFT_SAMPLE,
  output logic [SAMPLE_W-1:0]        O_RIGHT_SAMPLE,
  output logic                       O_SAMPLE_VALID,
  output logic                       O_OVERRUN,
  output logic                       O_SOUND_EN
);

  localparam int ACC_W  = SAMPLE_W + 2;
  localparam int PROD_W = ACC_W + 5;
  localparam int CNT_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  mix_state_t                 r_state, w_state_next;
  logic [7:0]                 r_nr50, r_nr51;
  logic                       r_master;
  logic [NUM_CH*SAMPLE_W-1:0] r_wave;
  logic [2:0]                 r_vol_l, r_vol_r;
  logic [NUM_CH-1:0]          r_route_l, r_route_r;
  logic                       r_on;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [ACC_W-1:0]    r_acc_l, r_acc_r;
  logic signed [SAMPLE_W-1:0] r_scl_l, r_scl_r, r_out_l, r_out_r;
  logic                       r_valid;
  logic [7:0]                 w_rd_data;
  logic                       w_rd_hit, w_overrun;
  logic signed [SAMPLE_W-1:0] w_ch, w_mix_l, w_mix_r;
  logic signed [ACC_W-1:0]    w_ch_ext;
  logic signed [4:0]          w_gain_l, w_gain_r;
  logic signed [PROD_W-1:0]   w_mul_l, w_mul_r;

  // Turning the master off wipes NR50/NR51 and locks them until it is turned back on.
  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_nr50   <= '0;
      r_nr51   <= '0;
      r_master <= 1'b0;
    end else if (!I_IOREG_WE_L) begin
      if (I_IOREG_ADDR == NR52_ADDR) begin
        r_master <= IO_IOREG_DATA[7];
        if (!IO_IOREG_DATA[7]) begin
          r_nr50 <= '0;
          r_nr51 <= '0;
        end
      end else if (r_master && I_IOREG_ADDR == NR50_ADDR) begin
        r_nr50 <= IO_IOREG_DATA;
      end else if (r_master && I_IOREG_ADDR == NR51_ADDR) begin
        r_nr51 <= IO_IOREG_DATA;
      end
    end
  end

  always_comb begin
    w_rd_data = 8'h00;
    w_rd_hit  = 1'b1;
    case (I_IOREG_ADDR)
      NR50_ADDR: w_rd_data = r_nr50;
      NR51_ADDR: w_rd_data = r_nr51;
      NR52_ADDR: w_rd_data = {r_master, 3'b111, I_CH_ON};
      default:   w_rd_hit  = 1'b0;
    endcase
  end

  assign IO_IOREG_DATA = (!I_IOREG_RE_L && w_rd_hit) ? w_rd_data : 8'hzz;

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) r_state <= ST_IDLE;
    else            r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_overrun    = 1'b0;
    case (r_state)
      ST_IDLE:  if (I_STROBE) w_state_next = ST_LATCH;
      ST_LATCH: w_state_next = ST_ACC;
      ST_ACC:   if (r_cnt == CNT_W'(NUM_CH - 1)) w_state_next = ST_SCALE;
`ifdef SOUND_MIXER_DC_FILTER_EN
      ST_SCALE: w_state_next = ST_FILT;
`else
      ST_SCALE: w_state_next = ST_DONE;
`endif
      ST_FILT:  w_state_next = ST_DONE;
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
    if (I_STROBE && r_state != ST_IDLE) w_overrun = 1'b1;
  end

  assign w_ch     = r_wave[r_cnt*SAMPLE_W +: SAMPLE_W];
  assign w_ch_ext = ACC_W'(w_ch);
  assign w_gain_l = $signed({2'b00, r_vol_l} + 5'd1);
  assign w_gain_r = $signed({2'b00, r_vol_r} + 5'd1);
  assign w_mul_l  = PROD_W'(r_acc_l) * PROD_W'(w_gain_l);
  assign w_mul_r  = PROD_W'(r_acc_r) * PROD_W'(w_gain_r);

  always_ff @(posedge I_CLK or negedge I_RESET_L) begin
    if (!I_RESET_L) begin
      r_wave    <= '0;
      r_vol_l   <= '0;
      r_vol_r   <= '0;
      r_route_l <= '0;
      r_route_r <= '0;
      r_on      <= 1'b0;
      r_cnt     <= '0;
      r_acc_l   <= '0;
      r_acc_r   <= '0;
      r_scl_l   <= '0;
      r_scl_r   <= '0;
      r_out_l   <= '0;
      r_out_r   <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        ST_LATCH: begin
          r_wave    <= I_CH_WAVEFORM;
          r_vol_l   <= r_nr50[6:4];
          r_vol_r   <= r_nr50[2:0];
          r_route_l <= r_nr51[4 +: NUM_CH];
          r_route_r <= r_nr51[0 +: NUM_CH];
          r_on      <= r_master;
          r_cnt     <= '0;
          r_acc_l   <= '0;
          r_acc_r   <= '0;
        end
        ST_ACC: begin
          if (r_route_l[r_cnt]) r_acc_l <= r_acc_l + w_ch_ext;
          if (r_route_r[r_cnt]) r_acc_r <= r_acc_r + w_ch_ext;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_SCALE: begin
          r_scl_l <= r_on ? SAMPLE_W'(w_mul_l >>> OUT_SHIFT) : '0;
          r_scl_r <= r_on ? SAMPLE_W'(w_mul_r >>> OUT_SHIFT) : '0;
        end
        ST_DONE: begin
          r_out_l <= w_mix_l;
          r_out_r <= w_mix_r;
          r_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SOUND_MIXER_DC_FILTER_EN
  logic w_filt_step;
  assign w_filt_step = (r_state == ST_FILT);

  sound_dc_filter #(.SAMPLE_W(SAMPLE_W)) u_dc_l (
    .i_clk(I_CLK), .i_rst_n(I_RESET_L), .i_step(w_filt_step),
    .i_bypass(!r_on), .i_x(r_scl_l), .o_y(w_mix_l)
  );
  sound_dc_filter #(.SAMPLE_W(SAMPLE_W)) u_dc_r (
    .i_clk(I_CLK), .i_rst_n(I_RESET_L), .i_step(w_filt_step),
    .i_bypass(!r_on), .i_x(r_scl_r), .o_y(w_mix_r)
  );
`else
  assign w_mix_l = r_scl_l;
  assign w_mix_r = r_scl_r;
`endif

  assign O_LEFT_SAMPLE  = r_out_l;
  assign O_RIGHT_SAMPLE = r_out_r;
  assign O_SAMPLE_VALID = r_valid;
  assign O_OVERRUN      = w_overrun;
  assign O_SOUND_EN     = r_master;

endmodule

// File: tb/tb_sound_mixer.sv
// Bench for sound_mixer: directed register writes and strobes queue expected
// L/R pairs; an independent monitor checks every O_SAMPLE_VALID against the queue.
module tb_sound_mixer;
  import sound_mixer_pkg::*;

  localparam int SW  = 20;
  localparam int LAT = 7;

  typedef struct {
    int            cyc;
    logic [SW-1:0] l;
    logic [SW-1:0] r;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   addr = '0;
  logic [7:0]    drv = '0;
  logic          oe = 1'b0;
  wire  [7:0]    bus;
  logic          we_l = 1'b1;
  logic          re_l = 1'b1;
  logic [4*SW-1:0] wave = '0;
  logic [3:0]    ch_on = 4'b0101;
  logic          strobe = 1'b0;
  logic [SW-1:0] o_l, o_r;
  logic          o_valid, o_overrun, o_en;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int n_valid = 0;
  int n_ovr = 0;
  exp_t q[$];

  assign bus = oe ? drv : 8'hzz;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sound_mixer dut (
    .I_CLK(clk), .I_RESET_L(rst_n), .I_IOREG_ADDR(addr), .IO_IOREG_DATA(bus),
    .I_IOREG_WE_L(we_l), .I_IOREG_RE_L(re_l), .I_CH_WAVEFORM(wave), .I_CH_ON(ch_on),
    .I_STROBE(strobe), .O_LEFT_SAMPLE(o_l), .O_RIGHT_SAMPLE(o_r),
    .O_SAMPLE_VALID(o_valid), .O_OVERRUN(o_overrun), .O_SOUND_EN(o_en)
  );

  function automatic logic [31:0] sx(input logic [SW-1:0] v);
    return 32'($signed(v));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, $signed(act), act, $signed(exp), exp);
    end else begin
      $display("ok   %s: %0d", nm, $signed(act));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    tick();
    addr = a; drv = d; oe = 1'b1; we_l = 1'b0;
    tick();
    we_l = 1'b1; oe = 1'b0;
    $display("wr   %h <= %h", a, d);
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] exp);
    tick();
    addr = a; re_l = 1'b0;
    #2;
    chk(nm, {24'd0, bus}, {24'd0, exp});
    re_l = 1'b1;
  endtask

  task automatic mix(input logic [SW-1:0] el, input logic [SW-1:0] er);
    tick();
    strobe = 1'b1;
    q.push_back('{cyc + 1 + LAT, el, er});
    $display("strb expect L=%0d R=%0d", $signed(el), $signed(er));
    tick();
    strobe = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (q.size() != 0 && k < 40) begin
      tick();
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d samples outstanding, required 0", q.size());
      q.delete();
    end
    repeat (2) tick();
  endtask

  task automatic set_wave(input int c4, input int c3, input int c2, input int c1);
    wave = {SW'(c4), SW'(c3), SW'(c2), SW'(c1)};
  endtask

  // Monitor: every valid pulse must match the oldest queued expectation and its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (o_overrun) n_ovr++;
      if (o_valid) begin
        n_valid++;
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_valid: got L=%0d R=%0d, required no sample", $signed(o_l), $signed(o_r));
        end else begin
          e = q.pop_front();
          chk("latency_cycle", 32'(cyc), 32'(e.cyc));
          chk("left_sample", sx(o_l), sx(e.l));
          chk("right_sample", sx(o_r), sx(e.r));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int o0;
    repeat (3) tick();
    chk("rst_left", sx(o_l), 32'd0);
    chk("rst_right", sx(o_r), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_sound_en", 32'(o_en), 32'd0);
    rst_n = 1'b1;

    rd_chk("nr52_read_off", NR52_ADDR, 8'h75);
    rd_chk("nr50_read_rst", NR50_ADDR, 8'h00);
    wr(NR52_ADDR, 8'h80);
    chk("sound_en_on", 32'(o_en), 32'd1);
    rd_chk("nr52_read_on", NR52_ADDR, 8'hF5);

    wr(NR50_ADDR, 8'h77);
    wr(NR51_ADDR, 8'hFF);
    rd_chk("nr50_readback", NR50_ADDR, 8'h77);
    rd_chk("nr51_readback", NR51_ADDR, 8'hFF);
    set_wave(1000, 1000, 1000, 1000);
    mix(SW'(1000), SW'(1000));
    drain();

    // ch1 left only at gain 1: -2000/32 floors to -63
    wr(NR51_ADDR, 8'h10);
    wr(NR50_ADDR, 8'h07);
    set_wave(500, 500, 500, -2000);
    mix(SW'(-63), SW'(0));
    drain();

    // left = ch4+ch1 = 2500 *4 >>5 = 312 ; right = ch3+ch2 = 1500 *6 >>5 = 281
    wr(NR50_ADDR, 8'h35);
    wr(NR51_ADDR, 8'h96);
    set_wave(-500, 2500, -1000, 3000);
    mix(SW'(312), SW'(281));
    drain();

    wr(NR50_ADDR, 8'h77);
    wr(NR51_ADDR, 8'hFF);
    set_wave(524287, 524287, 524287, 524287);
    mix(SW'(524287), SW'(524287));
    drain();
    set_wave(-524288, -524288, -524288, -524288);
    mix(SW'(-524288), SW'(-524288));
    drain();

    // Changes after LATCH must not affect the mix in flight
    set_wave(1000, 1000, 1000, 1000);
    mix(SW'(1000), SW'(1000));
    wr(NR50_ADDR, 8'h00);
    wave = '0;
    drain();
    set_wave(1000, 1000, 1000, 1000);
    mix(SW'(125), SW'(125));
    drain();

    n0 = n_valid;
    o0 = n_ovr;
    tick();
    strobe = 1'b1;
    q.push_back('{cyc + 1 + LAT, SW'(125), SW'(125)});
    $display("strb expect L=125 R=125 (followed by dropped strobe)");
    tick();
    strobe = 1'b0;
    tick();
    tick();
    strobe = 1'b1;
    #1;
    chk("overrun_pulse", 32'(o_overrun), 32'd1);
    tick();
    strobe = 1'b0;
    drain();
    chk("overrun_count", 32'(n_ovr - o0), 32'd1);
    chk("valid_count_overrun", 32'(n_valid - n0), 32'd1);

    wr(NR52_ADDR, 8'h00);
    chk("sound_en_off", 32'(o_en), 32'd0);
    wr(NR50_ADDR, 8'h77);
    rd_chk("nr50_locked_off", NR50_ADDR, 8'h00);
    rd_chk("nr51_cleared_off", NR51_ADDR, 8'h00);
    rd_chk("nr52_read_off2", NR52_ADDR, 8'h75);
    set_wave(1000, 1000, 1000, 1000);
    mix(SW'(0), SW'(0));
    drain();

    wr(NR52_ADDR, 8'h80);
    wr(NR50_ADDR, 8'h77);
    wr(NR51_ADDR, 8'hFF);
    mix(SW'(1000), SW'(1000));
    drain();
    n0 = n_valid;
    tick();
    strobe = 1'b1;
    $display("strb reset during ACC cycle 2, no sample expected");
    tick();
    strobe = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk("midmix_rst_left", sx(o_l), 32'd0);
    chk("midmix_rst_right", sx(o_r), 32'd0);
    chk("midmix_rst_valid", 32'(o_valid), 32'd0);
    chk("midmix_rst_sound_en", 32'(o_en), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("midmix_no_valid", 32'(n_valid - n0), 32'd0);
    rd_chk("nr50_after_rst", NR50_ADDR, 8'h00);
    chk("queue_empty_end", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
